serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 91 +++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b with registered diff/borrow_out.
// Define SUB_ABS_EN to add a NEG state that returns |a - b| in diff.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef SUB_ABS_EN
    typedef enum logic [1:0] {IDLE, SHIFT, NEG, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif
    state_t           state;
    logic [WIDTH-1:0] a_r, b_r, res, next_res;
    logic [CW-1:0]    cnt;
    logic             bin, sum_bit, bout, last;

    always_comb begin
        sum_bit  = a_r[0] ^ b_r[0] ^ bin;
        bout     = (~a_r[0] & b_r[0]) | (~(a_r[0] ^ b_r[0]) & bin);
        next_res = {sum_bit, res[WIDTH-1:1]};
        last     = cnt == CW'(WIDTH - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            res        <= '0;
            cnt        <= '0;
            bin        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_r   <= a;
                    b_r   <= b;
                    bin   <= 1'b0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= SHIFT;
                end
                SHIFT: begin
                    a_r <= a_r >> 1;
                    b_r <= b_r >> 1;
                    res <= next_res;
                    bin <= bout;
                    cnt <= cnt + 1'b1;
                    if (last) begin
`ifdef SUB_ABS_EN
                        state <= NEG;
`else
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= next_res;
                        borrow_out <= bout;
`endif
                    end
                end
`ifdef SUB_ABS_EN
                NEG: begin
                    state      <= DONE;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    diff       <= bin ? -res : res;
                    borrow_out <= bin;
                end
`endif
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
